// File: rtl/muskoka_wb_arbiter_pkg.sv
// Shared widths, FSM state encoding and helpers for the muskoka Wishbone arbiter.
package muskoka_wb_arbiter_pkg;

    localparam int unsigned MAX_M  = 8;
    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 32;
    localparam int unsigned TMO_W  = 16;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_OWN
    } state_e;

    // Index width for n masters, never below 1 bit.
    function automatic int unsigned clog2w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/muskoka_wb_arbiter_if.sv
// Bundle of per-master request lines and the shared slave port of the muskoka arbiter.
interface muskoka_wb_arbiter_if #(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
);
    localparam int unsigned SW = DW / 8;

    logic [NUM_M-1:0]    m_cyc_i;
    logic [NUM_M-1:0]    m_stb_i;
    logic [NUM_M-1:0]    m_we_i;
    logic [NUM_M*SW-1:0] m_sel_i;
    logic [NUM_M*AW-1:0] m_adr_i;
    logic [NUM_M*DW-1:0] m_dat_i;
    logic [DW-1:0]       m_dat_o;
    logic [NUM_M-1:0]    m_ack_o;
    logic [NUM_M-1:0]    m_err_o;

    logic                s_cyc_o;
    logic                s_stb_o;
    logic                s_we_o;
    logic [SW-1:0]       s_sel_o;
    logic [AW-1:0]       s_adr_o;
    logic [DW-1:0]       s_dat_o;
    logic [DW-1:0]       s_dat_i;
    logic                s_ack_i;
    logic                s_err_i;

    logic [NUM_M-1:0]    grant_o;

    // Arbiter view: it masters the shared slave port.
    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output grant_o
    );

    // Surrounding system view: masters and the bus decoder.
    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        output s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  grant_o
    );

endinterface

// File: rtl/muskoka_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module muskoka_wb_arbiter_rr_pick
    import muskoka_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_M = 2,
    localparam int unsigned IW   = clog2w(NUM_M)
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [NUM_M-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             valid_o
);

    int unsigned p;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        p       = 32'(ptr_i);
        // Outer loop walks priority order, inner loop matches it to a constant bit position.
        for (int unsigned i = 0; i < NUM_M; i++) begin
            for (int unsigned j = 0; j < NUM_M; j++) begin
                if (!valid_o && req_i[j] && (((p + i) % NUM_M) == j)) begin
                    valid_o  = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/muskoka_wb_arbiter.sv
// Round-robin Wishbone B3 classic arbiter granting whole cyc tenures to one of NUM_M masters.
// Optional WB_ARB_TIMEOUT_EN: forces a one-cycle err after TIMEOUT stalled strobe cycles.
module muskoka_wb_arbiter
    import muskoka_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_M   = 2,
    parameter int unsigned AW      = BUS_AW,
    parameter int unsigned DW      = BUS_DW,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                  clk_i,
    input logic                  rst_i,
    muskoka_wb_arbiter_if.master bus
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = clog2w(NUM_M);

    if (NUM_M < 2 || NUM_M > MAX_M) begin : g_bad_num_m
        $error("NUM_M must be within 2..MAX_M");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT must be within 1..65535");
    end

    state_e           state_q;
    logic [NUM_M-1:0] grant_q;
    logic [IW-1:0]    gidx_q;
    logic [IW-1:0]    ptr_q;

    logic [NUM_M-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;

    logic             own;
    logic             g_cyc;
    logic             g_stb;
    logic             g_we;
    logic [SW-1:0]    g_sel;
    logic [AW-1:0]    g_adr;
    logic [DW-1:0]    g_dat;
    logic             s_stb;
    logic             tmo_hit;

    muskoka_wb_arbiter_rr_pick #(
        .NUM_M (NUM_M)
    ) u_pick (
        .req_i   (bus.m_cyc_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_gnt;
                        gidx_q  <= pick_idx;
                        state_q <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    // Returning to IDLE always costs one cycle, which lets the pointer move on.
                    if (!g_cyc) begin
                        grant_q <= '0;
                        ptr_q   <= (gidx_q == IW'(NUM_M - 1)) ? '0 : gidx_q + IW'(1);
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign own = (state_q == ST_OWN);

    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_sel = '0;
        g_adr = '0;
        g_dat = '0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            if (own && gidx_q == IW'(k)) begin
                g_cyc = bus.m_cyc_i[k];
                g_stb = bus.m_stb_i[k];
                g_we  = bus.m_we_i[k];
                g_sel = bus.m_sel_i[k*SW +: SW];
                g_adr = bus.m_adr_i[k*AW +: AW];
                g_dat = bus.m_dat_i[k*DW +: DW];
            end
        end
    end

    // A strobe without cycle is never presented, so dropping cyc aborts the slave transfer.
    assign s_stb = g_cyc & g_stb;

`ifdef WB_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q;

    assign tmo_hit = s_stb && !bus.s_ack_i && !bus.s_err_i && (tmo_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || !own) begin
            tmo_q <= '0;
        end else if (bus.s_ack_i || bus.s_err_i || tmo_hit) begin
            tmo_q <= '0;
        end else if (s_stb) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign bus.s_cyc_o = g_cyc;
    assign bus.s_stb_o = s_stb;
    assign bus.s_we_o  = g_we;
    assign bus.s_sel_o = g_sel;
    assign bus.s_adr_o = g_adr;
    assign bus.s_dat_o = g_dat;

    // grant_q is zero outside OWN, so terminations in IDLE never reach a master.
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.m_ack_o = grant_q & {NUM_M{bus.s_ack_i}};
    assign bus.m_err_o = grant_q & {NUM_M{bus.s_err_i | tmo_hit}};
    assign bus.grant_o = grant_q;

endmodule

// File: tb/tb_muskoka_wb_arbiter.sv
// Self-checking bench for muskoka_wb_arbiter: tenure-level model checked every cycle plus
// directed scenarios with literal expectations. Honours WB_ARB_TIMEOUT_EN like the design.
module tb_muskoka_wb_arbiter;

    localparam int unsigned NM  = 2;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int          TMO = 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muskoka_wb_arbiter_if #(.NUM_M(NM), .AW(AW), .DW(DW)) bus ();

    muskoka_wb_arbiter #(
        .NUM_M   (NM),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    // Model: who owns the bus (-1 = nobody), where the rotation resumes, stalled-strobe count.
    int owner = -1;
    int ptr   = 0;
    int stall = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input bit c, input bit s, input bit w,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        bus.m_cyc_i[k] = c;
        bus.m_stb_i[k] = s;
        bus.m_we_i[k]  = w;
        bus.m_sel_i[k*SW +: SW] = '1;
        bus.m_adr_i[k*AW +: AW] = adr;
        bus.m_dat_i[k*DW +: DW] = dat;
    endtask

    // Tenure bookkeeping at each clock edge.
    int nown, nptr, nst, kk;
    always @(posedge clk) begin
        nown = owner;
        nptr = ptr;
        nst  = stall;
        if (rst) begin
            nown = -1;
            nptr = 0;
            nst  = 0;
        end else if (owner < 0) begin
            nst = 0;
            for (int i = 0; i < NM; i++) begin
                kk = (ptr + i) % NM;
                if (nown < 0 && bus.m_cyc_i[kk]) nown = kk;
            end
        end else if (!bus.m_cyc_i[owner]) begin
            nown = -1;
            nptr = (owner + 1) % NM;
            nst  = 0;
        end else if (bus.s_ack_i || bus.s_err_i) begin
            nst = 0;
        end else if (bus.m_stb_i[owner]) begin
            nst = (stall == TMO - 1) ? 0 : stall + 1;
        end
        owner <= nown;
        ptr   <= nptr;
        stall <= nst;
    end

    // Every-cycle comparison of all outputs against the model.
    logic          e_cyc, e_stb, e_we, hit;
    logic [SW-1:0] e_sel;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [NM-1:0] e_ack, e_err, e_gnt;
    always @(negedge clk) begin
        if (check_en) begin
            e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
            e_sel = '0;   e_adr = '0;   e_dat = '0;
            e_ack = '0;   e_err = '0;   e_gnt = '0;
            if (owner >= 0) begin
                e_cyc = bus.m_cyc_i[owner];
                e_stb = e_cyc && bus.m_stb_i[owner];
                e_we  = bus.m_we_i[owner];
                e_sel = bus.m_sel_i[owner*SW +: SW];
                e_adr = bus.m_adr_i[owner*AW +: AW];
                e_dat = bus.m_dat_i[owner*DW +: DW];
                e_gnt[owner] = 1'b1;
                hit = TMO_EN && e_stb && !bus.s_ack_i && !bus.s_err_i && (stall == TMO - 1);
                e_ack[owner] = bus.s_ack_i;
                e_err[owner] = bus.s_err_i || hit;
            end
            chk("s_cyc_o", bus.s_cyc_o, e_cyc);
            chk("s_stb_o", bus.s_stb_o, e_stb);
            chk("s_we_o",  bus.s_we_o,  e_we);
            chk("s_sel_o", bus.s_sel_o, e_sel);
            chk("s_adr_o", bus.s_adr_o, e_adr);
            chk("s_dat_o", bus.s_dat_o, e_dat);
            chk("m_dat_o", bus.m_dat_o, bus.s_dat_i);
            chk("m_ack_o", bus.m_ack_o, e_ack);
            chk("m_err_o", bus.m_err_o, e_err);
            chk("grant_o", bus.grant_o, e_gnt);
        end
    end

    task automatic wait_grant(output int g);
        g = -1;
        for (int c = 0; c < 8; c++) begin
            mid();
            if (bus.grant_o != '0) begin
                g = bus.grant_o[1] ? 1 : 0;
                break;
            end
            tick();
        end
        if (g < 0) chk("grant timeout", 64'd0, 64'd1);
    endtask

    int g;

    initial begin
        bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
        bus.m_sel_i = '0; bus.m_adr_i = '0; bus.m_dat_i = '0;
        bus.s_dat_i = '0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_en = 1'b1;

        // 1: reset in the middle of a tenure
        set_m(1, 1, 1, 0, 32'h200, 32'h0);
        tick();
        mid();
        chk("t1 grant m1", bus.grant_o, 2'b10);
        rst = 1'b1;
        tick();
        mid();
        chk("t1 rst s_cyc", bus.s_cyc_o, 1'b0);
        chk("t1 rst grant", bus.grant_o, 2'b00);
        tick();
        rst = 1'b0;
        set_m(0, 1, 1, 1, 32'h300, 32'h1111);
        tick();
        mid();
        chk("t1 first grant m0", bus.grant_o, 2'b01);
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        tick();

        // 2: single master read with late ack
        set_m(1, 1, 1, 0, 32'h100, 32'h0);
        mid();
        chk("t2 latency s_cyc", bus.s_cyc_o, 1'b0);
        tick();
        mid();
        chk("t2 s_cyc", bus.s_cyc_o, 1'b1);
        chk("t2 s_adr", bus.s_adr_o, 32'h100);
        tick();
        tick();
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 32'hCAFE_F00D;
        mid();
        chk("t2 m_ack", bus.m_ack_o, 2'b10);
        chk("t2 m_dat", bus.m_dat_o, 32'hCAFE_F00D);
        tick();
        bus.s_ack_i = 1'b0;
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        tick();
        mid();
        chk("t2 idle grant", bus.grant_o, 2'b00);

        // 3: simultaneous requests from reset alternate
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        set_m(0, 1, 1, 0, 32'h10, 32'h0);
        set_m(1, 1, 1, 1, 32'h20, 32'h5);
        for (int t = 0; t < 4; t++) begin
            wait_grant(g);
            chk("t3 order", g, t % 2);
            bus.s_ack_i = 1'b1;
            tick();
            bus.s_ack_i = 1'b0;
            set_m(g, 0, 0, 0, 32'h0, 32'h0);
            if (t == 3) set_m(1 - g, 0, 0, 0, 32'h0, 32'h0);
            tick();
            mid();
            chk("t3 idle gap", bus.grant_o, 2'b00);
            if (t < 3) set_m(g, 1, 1, g == 1, 32'h10 + 32'(g) * 32'h10, 32'(g) * 5);
        end

        // 4: burst holds the grant while the other master waits
        set_m(0, 1, 1, 1, 32'h400, 32'hA0);
        set_m(1, 1, 1, 0, 32'h500, 32'h0);
        tick();
        for (int b = 0; b < 4; b++) begin
            bus.s_ack_i = 1'b1;
            bus.s_dat_i = 32'(b);
            bus.m_adr_i[0 +: AW] = 32'h400 + 32'(b) * 4;
            mid();
            chk("t4 hold", bus.grant_o, 2'b01);
            tick();
        end
        bus.s_ack_i = 1'b0;
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        mid();
        chk("t4 release cycle", bus.grant_o, 2'b01);
        tick();
        mid();
        chk("t4 gap", bus.grant_o, 2'b00);
        tick();
        mid();
        chk("t4 m1 next", bus.grant_o, 2'b10);
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        tick();
        tick();

        // 5: master aborts, slave acks late
        set_m(1, 1, 1, 0, 32'h600, 32'h0);
        tick();
        mid();
        chk("t5 grant", bus.grant_o, 2'b10);
        set_m(1, 0, 0, 0, 32'h600, 32'h0);
        #1;
        chk("t5 abort s_cyc", bus.s_cyc_o, 1'b0);
        tick();
        bus.s_ack_i = 1'b1;
        mid();
        chk("t5 late ack", bus.m_ack_o, 2'b00);
        chk("t5 idle", bus.grant_o, 2'b00);
        tick();
        bus.s_ack_i = 1'b0;

        // 6: hung slave; err only when the timeout is built in, ack beats a pending timeout
        set_m(0, 1, 1, 1, 32'h40, 32'hBEEF);
        tick();
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) bus.s_ack_i = 1'b1;
            mid();
            chk("t6 err", bus.m_err_o, (TMO_EN && i == 8) ? 2'b01 : 2'b00);
            if (i == 16) chk("t6 ack wins", bus.m_ack_o, 2'b01);
            tick();
        end
        bus.s_ack_i = 1'b0;
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

endmodule
